issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised instruction queue between the fetch stage and the IF/ID registers of the multi-issue pipeline. It decouples fetch from issue. Fetch pushes up to LANES instruction packets per cycle. Decode pops 0..LANES packets per cycle in program order, and unissued packets are kept for the next cycle, which gives partial issue. Load-use stalls are absorbed through the hold input. Branch-correction and jr redirects empty the queue through the flush input.

## Interface
- LANES, 2, issue width (1..4); the number of packets pushed/popped per cycle.
- DEPTH, 8, number of entries; a power of two and ≥ 2*LANES.
- DATA_W, 52, packet width ({return_addr[9:0], instruction[31:0], branch_addr[9:0]}).
- CNT_W, $clog2(DEPTH+1), derived; not to be overridden.
- LW, $clog2(LANES+1), derived; width of the lane-count fields.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all queued packets (redirect).
- hold  in  1  stall the issue side; no pop this cycle.
- in_valid  in  LANES  per-lane push valid; lane 0 is the oldest.
- in_data  in  LANES*DATA_W  push packets; lane i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  1  queue can accept a full LANES-wide push this cycle.
- out_valid  out  LANES  thermometer code: lane i is valid iff count > i.
- out_data  out  LANES*DATA_W  the LANES oldest packets; lane 0 is the head.
- deq_cnt  in  LW  number of lanes the consumer takes this cycle.
- count  out  CNT_W  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Storage: DEPTH×DATA_W circular array, plus head and tail pointers ($clog2(DEPTH) bits, wrapping modulo DEPTH) and the count register.
- Push count enq_n: the number of consecutive 1s in in_valid starting at lane 0. Bits after the first 0 are ignored.
- A push occurs iff in_ready && enq_n > 0. Lane k is written to entry (tail+k) mod DEPTH, and tail advances by enq_n.
- in_ready = (DEPTH − count) ≥ LANES. It is computed from the registered count only and has no combinational path from deq_cnt or hold. When in_ready=0 the whole push is dropped; there are no partial pushes.
- Pop count deq_n: 0 if hold=1; otherwise min(deq_cnt, popcount(out_valid)). Head advances by deq_n.
- count_next = count + (push ? enq_n : 0) − deq_n. Simultaneous push and pop in one cycle is legal.
- out_data lane i = entry (head+i) mod DEPTH when out_valid[i]=1, otherwise all zeros. A zero packet decodes as a nop, matching IF/ID flush semantics.
- flush=1: head, tail and count become 0 at the next edge. Any push and pop in the same cycle is discarded, so flush dominates.
- Entry contents are not reset; correctness relies on the out_data masking.

## Timing
- Reset (asynchronous, takes effect immediately): head=0, tail=0, count=0. The outputs are then out_valid=0, out_data=0, in_ready=1, empty=1, full=0.
- Pointer and count updates take effect at the first rising edge after rst deasserts.
- Latency: a packet pushed at edge t appears on out_data/out_valid after edge t (fall-through is not supported). Minimum fetch-to-issue latency is 1 cycle.
- All outputs are combinational from registered state only.
- Wrap-around: an index of head+i or tail+k ≥ DEPTH wraps to 0. Throughput is unaffected.
- Full boundary: with count = DEPTH−LANES+1, in_ready=0 even if the same-cycle pop would have freed space (conservative by design).
- deq_cnt > valid lanes is clamped, and count never underflows.
- Flush during a full queue, or in the same cycle as hold, still yields count=0 next cycle.
- Reset asserted mid-operation: state clears immediately, and no partial update survives.

## Test plan
- Reset/basic (LANES=2, DEPTH=8): after rst drops, push A,B (in_valid=2'b11) -> next cycle count=2, out_valid=2'b11, out_data lane0=A, lane1=B; deq_cnt=2 -> count=0, empty=1, out_data=0.
- Fill/full: push 4 cycles of pairs without popping -> count=8, full=1, in_ready=0 from count=7 onward; a push presented at count=7 is dropped and count stays 7.
- Partial issue: queue holds P0..P3; deq_cnt=1 -> next out lane0=P1, lane1=P2, count=3; deq_cnt=3 with count=1 -> clamped to 1, count=0.
- Wrap-around: 12 cycles of push-2/pop-2 -> order preserved across index 7->0, count stays 2, no packet lost or duplicated.
- Hold and flush: hold=1 with deq_cnt=2 and a push -> count+2, head unchanged; flush=1 with a simultaneous push and pop -> count=0, out_valid=0 next cycle.
- Non-thermometer valid: in_valid=2'b10 -> nothing pushed; 2'b01 -> one packet pushed, count+1; async rst pulse mid-stream -> out_valid=0 in the same cycle.

Source files
------------

// File: rtl/issue_queue_if.sv
// Fetch/decode handshake bundle for the issue queue.
// The slave modport is the queue itself; the master modport is the
// fetch + decode side that pushes packets and consumes them.
interface issue_queue_if #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 52
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LW    = $clog2(LANES + 1);

    logic                    flush;
    logic                    hold;
    logic [LANES-1:0]        in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_ready;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LW-1:0]           deq_cnt;
    logic [CNT_W-1:0]        count;
    logic                    empty;
    logic                    full;

    modport master (
        output flush, hold, in_valid, in_data, deq_cnt,
        input  in_ready, out_valid, out_data, count, empty, full
    );

    modport slave (
        input  flush, hold, in_valid, in_data, deq_cnt,
        output in_ready, out_valid, out_data, count, empty, full
    );
endinterface

// File: rtl/issue_queue.sv
// Multi-lane instruction queue between fetch and the IF/ID registers.
// Fetch pushes up to LANES packets per cycle, decode pops 0..LANES in
// program order; hold stalls the issue side, flush empties the queue.
module issue_queue #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 52
) (
    input logic        clk,
    input logic        rst,
    issue_queue_if.slave bus
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LW    = $clog2(LANES + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CNT_W-1:0]  count;

    logic [LW-1:0]           enq_n;
    logic [LW-1:0]           valid_n;
    logic [LW-1:0]           deq_n;
    logic                    push;
    logic                    in_ready;
    logic [CNT_W-1:0]        count_next;
    logic [LANES-1:0]        out_valid;
    logic [LANES*DATA_W-1:0] out_data;

    // Push length: run of valid lanes starting at lane 0; lanes after a gap are ignored.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic run;
        enq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            run = run & bus.in_valid[i];
            if (run) enq_n = enq_n + LW'(1);
        end
    end

    // Space check uses only the registered count, so a same-cycle pop never frees room.
    assign in_ready = (count <= CNT_W'(DEPTH - LANES));
    assign push     = in_ready && (enq_n != '0);

    // Pop length: clamp the consumer request to the lanes actually presented.
    always_comb begin
        valid_n = (count >= CNT_W'(LANES)) ? LW'(LANES) : LW'(count);
        if (bus.hold)
            deq_n = '0;
        else
            deq_n = (bus.deq_cnt < valid_n) ? bus.deq_cnt : valid_n;
    end

    // Next occupancy: simultaneous push and pop are allowed.
    always_comb begin
        count_next = count;
        if (push) count_next = count_next + CNT_W'(enq_n);
        count_next = count_next - CNT_W'(deq_n);
    end

    // Pointer and occupancy state; flush dominates any push or pop in the same cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_n);
            if (push) tail <= tail + PW'(enq_n);
            count <= count_next;
        end
    end

    // Packet storage; lane k lands at tail+k, wrapping modulo DEPTH.
    // NOTE: the array has no reset; stale entries are never visible because out_data is masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int k = 0; k < LANES; k++) begin
                if (k < int'(enq_n))
                    mem[tail + PW'(k)] <= bus.in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Issue window: the LANES oldest packets, zeroed (nop) beyond the occupied entries.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_valid[i] = (count > CNT_W'(i));
            if (out_valid[i])
                out_data[i*DATA_W +: DATA_W] = mem[head + PW'(i)];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.count     = count;
    assign bus.empty     = (count == '0);
    assign bus.full      = (count == CNT_W'(DEPTH));
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue (LANES=2, DEPTH=8).
// The driver applies directed cycles and records which packets it expects
// to be accepted; the monitor checks the presented window every cycle and
// retires the packets the consumer takes.
module tb_issue_queue;
    localparam int LANES  = 2;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 52;

    logic clk = 1'b0;
    logic rst;

    issue_queue_if #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    issue_queue #(.LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [DATA_W-1:0] exp_q  [$];
    logic [DATA_W-1:0] pend_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare the window to the scoreboard, then retire popped packets
    // and append the packets accepted at the coming edge.
    int m_n;
    int m_d;
    logic [LANES-1:0] m_tv;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            m_n  = (exp_q.size() > LANES) ? LANES : exp_q.size();
            m_tv = LANES'((1 << m_n) - 1);
            check("out_valid", 64'(bus.out_valid), 64'(m_tv));
            check("count", 64'(bus.count), 64'(exp_q.size()));
            for (int i = 0; i < LANES; i++)
                check($sformatf("out_data_lane%0d", i), 64'(bus.out_data[i*DATA_W +: DATA_W]),
                      (i < m_n) ? 64'(exp_q[i]) : 64'd0);
            if (bus.flush) begin
                exp_q.delete();
                pend_q.delete();
            end else begin
                m_d = bus.hold ? 0 : int'(bus.deq_cnt);
                if (m_d > m_n) m_d = m_n;
                repeat (m_d) void'(exp_q.pop_front());
                while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
            end
        end
    end

    // One clock of stimulus; acc is the hand-computed number of lanes accepted.
    task automatic cyc(input logic [1:0] v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input int dq, input logic h, input logic f, input int acc);
        bus.in_valid = v;
        bus.in_data  = {b, a};
        bus.deq_cnt  = 2'(dq);
        bus.hold     = h;
        bus.flush    = f;
        if (acc >= 1) pend_q.push_back(a);
        if (acc >= 2) pend_q.push_back(b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int dq);
        cyc(2'b00, '0, '0, dq, 1'b0, 1'b0, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.deq_cnt  = '0;
        bus.hold     = 1'b0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data[DATA_W-1:0]) | 64'(bus.out_data[2*DATA_W-1:DATA_W]), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        rst = 1'b0;

        // Basic: push A,B then pop both.
        cyc(2'b11, 52'h0_000A, 52'h0_000B, 0, 0, 0, 2);
        check("basic_count", 64'(bus.count), 64'd2);
        idle(2);
        check("basic_empty", 64'(bus.empty), 64'd1);

        // Fill to full, then the count=7 boundary.
        cyc(2'b11, 52'h100, 52'h101, 0, 0, 0, 2);
        cyc(2'b11, 52'h102, 52'h103, 0, 0, 0, 2);
        cyc(2'b11, 52'h104, 52'h105, 0, 0, 0, 2);
        check("fill6_in_ready", 64'(bus.in_ready), 64'd1);
        cyc(2'b11, 52'h106, 52'h107, 0, 0, 0, 2);
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_in_ready", 64'(bus.in_ready), 64'd0);
        idle(1);
        check("cnt7_in_ready", 64'(bus.in_ready), 64'd0);
        check("cnt7_full", 64'(bus.full), 64'd0);
        cyc(2'b11, 52'hBAD0, 52'hBAD1, 0, 0, 0, 0);
        check("cnt7_drop_count", 64'(bus.count), 64'd7);
        cyc(2'b11, 52'hBAD2, 52'hBAD3, 2, 0, 0, 0);
        check("cnt7_pop_drop_count", 64'(bus.count), 64'd5);
        idle(2);
        idle(2);
        idle(3);
        check("clamp_count", 64'(bus.count), 64'd0);

        // Partial issue.
        cyc(2'b11, 52'h200, 52'h201, 0, 0, 0, 2);
        cyc(2'b11, 52'h202, 52'h203, 0, 0, 0, 2);
        idle(1);
        check("partial_count", 64'(bus.count), 64'd3);
        check("partial_lane0", 64'(bus.out_data[DATA_W-1:0]), 64'h201);
        idle(2);
        idle(3);
        check("partial_clamp_count", 64'(bus.count), 64'd0);

        // Wrap-around: steady push-2/pop-2.
        cyc(2'b11, 52'h300, 52'h301, 0, 0, 0, 2);
        for (int i = 1; i <= 12; i++) begin
            cyc(2'b11, 52'h300 + 52'(2*i), 52'h301 + 52'(2*i), 2, 0, 0, 2);
            check("wrap_count", 64'(bus.count), 64'd2);
        end

        // Hold with push: count grows, head stays.
        cyc(2'b11, 52'h400, 52'h401, 2, 1, 0, 2);
        check("hold_count", 64'(bus.count), 64'd4);
        check("hold_lane0", 64'(bus.out_data[DATA_W-1:0]), 64'h318);
        // Flush with simultaneous push and pop.
        cyc(2'b11, 52'h402, 52'h403, 2, 0, 1, 0);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        // Flush together with hold on a full queue.
        for (int i = 0; i < 4; i++) cyc(2'b11, 52'h500 + 52'(2*i), 52'h501 + 52'(2*i), 0, 0, 0, 2);
        cyc(2'b00, '0, '0, 2, 1, 1, 0);
        check("flush_full_count", 64'(bus.count), 64'd0);

        // Non-thermometer valid.
        cyc(2'b10, 52'h600, 52'h601, 0, 0, 0, 0);
        check("valid10_count", 64'(bus.count), 64'd0);
        cyc(2'b01, 52'h602, 52'h603, 0, 0, 0, 1);
        check("valid01_count", 64'(bus.count), 64'd1);
        cyc(2'b11, 52'h604, 52'h605, 0, 0, 0, 2);
        idle(0);

        // Asynchronous reset mid-stream.
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_count", 64'(bus.count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2'b11, 52'h700, 52'h701, 0, 0, 0, 2);
        idle(2);
        idle(0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
